// File: rtl/encoder_8to3_if.sv
// ----------------------------------------------------------------------------
// encoder_8to3_if
// Groups the request/result signals of the 8-to-3 priority encoder.
//
//   en     capture enable (driven by master)
//   in     N-bit request vector, bit i = request i (driven by master)
//   out    OUT_W-bit index of the highest asserted request (driven by slave)
//   valid  high when any request bit was set (driven by slave)
//
// master : the block that issues requests and consumes the index
// slave  : the encoder itself
// ----------------------------------------------------------------------------
interface encoder_8to3_if #(
   parameter int N     = 8,
   parameter int OUT_W = $clog2(N)
);

   logic             en;
   logic [N-1:0]     in;
   logic [OUT_W-1:0] out;
   logic             valid;

   modport master (
      output en,
      output in,
      input  out,
      input  valid
   );

   modport slave (
      input  en,
      input  in,
      output out,
      output valid
   );

endinterface : encoder_8to3_if

// File: rtl/encoder_8to3.sv
// ----------------------------------------------------------------------------
// encoder_8to3
// Priority encoder: reduces an N-bit multi-hot request vector to the binary
// index of its highest-numbered set bit, plus a valid flag (OR of all bits).
// With REG_OUT = 1 the result is registered (one-cycle latency, held while
// en = 0, cleared asynchronously by rst_n). With REG_OUT = 0 the result
// follows the request vector combinationally and clk/rst_n/en are unused.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears out/valid)
//   bus    encoder_8to3_if slave port: en, in -> out, valid
//
// The interface instance must be built with the same N as this module.
// ----------------------------------------------------------------------------
module encoder_8to3 #(
   parameter int N       = 8,
   parameter bit REG_OUT = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   encoder_8to3_if.slave       bus
);

   localparam int OUT_W = $clog2(N);

   logic [OUT_W-1:0] enc_idx;
   logic             enc_any;

   // Ascending scan: each later (higher) set bit overwrites the earlier hit,
   // so the surviving index is the highest asserted bit. All-zero leaves 0.
   // NOTE: both outputs get a default before the loop so every path assigns
   // them and no latch is inferred.
   always_comb begin
      enc_idx = '0;
      enc_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (bus.in[i]) begin
            enc_idx = OUT_W'(i);
            enc_any = 1'b1;
         end
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [OUT_W-1:0] out_q;
         logic             valid_q;

         // Only the two output registers hold state; en is not consulted
         // while rst_n is low because the reset branch wins.
         // NOTE: sequential state uses non-blocking assignments so all
         // registers update together from pre-edge values.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_q   <= '0;
               valid_q <= 1'b0;
            end else if (bus.en) begin
               out_q   <= enc_idx;
               valid_q <= enc_any;
            end
         end

         assign bus.out   = out_q;
         assign bus.valid = valid_q;
      end else begin : g_comb
         assign bus.out   = enc_idx;
         assign bus.valid = enc_any;
      end
   endgenerate

endmodule : encoder_8to3

// File: tb/tb_encoder_8to3.sv
// ----------------------------------------------------------------------------
// tb_encoder_8to3
// Self-checking bench for encoder_8to3 (N = 8, REG_OUT = 1). Inputs change on
// the falling edge; outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_encoder_8to3;

   localparam int N = 8;

   logic clk;
   logic rst_n;

   encoder_8to3_if #(.N(N)) bus ();

   encoder_8to3 #(.N(N), .REG_OUT(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_passed = 0;

   // Reference: index of the most significant set bit is floor(log2(v)),
   // i.e. $clog2(v+1)-1; zero has no set bit and maps to 0.
   function automatic logic [2:0] ref_idx(input logic [N-1:0] v);
      int u;
      u = int'(v);
      if (u == 0) return 3'd0;
      return 3'($clog2(u + 1) - 1);
   endfunction

   function automatic logic ref_valid(input logic [N-1:0] v);
      return (v != '0);
   endfunction

   // Drive a request on the falling edge, then wait past the next rising edge.
   task automatic capture(input logic [N-1:0] v, input logic e);
      @(negedge clk);
      bus.in = v;
      bus.en = e;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      bus.in = 8'hFF;
      bus.en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({bus.out, bus.valid} !== {3'd0, 1'b0})
            $display("FAIL reset_hold[%0d]: out=%0d valid=%b, want out=0 valid=0",
                     k, bus.out, bus.valid);
         else n_passed++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.out, bus.valid} !== {3'd7, 1'b1})
         $display("FAIL reset_release: out=%0d valid=%b, want out=7 valid=1",
                  bus.out, bus.valid);
      else n_passed++;
   endtask

   task automatic test_one_hot();
      for (int i = 0; i < N; i++) begin
         capture(8'(1 << i), 1'b1);
         n_checks++;
         if ({bus.out, bus.valid} !== {3'(i), 1'b1})
            $display("FAIL one_hot[%0d]: out=%0d valid=%b, want out=%0d valid=1",
                     i, bus.out, bus.valid, i);
         else n_passed++;
      end
   endtask

   task automatic test_multi_hot();
      logic [7:0] vec [4] = '{8'b0000_0011, 8'b1010_1010, 8'b1111_1111, 8'b0001_0110};
      logic [2:0] idx [4] = '{3'd1, 3'd7, 3'd7, 3'd4};
      for (int i = 0; i < 4; i++) begin
         capture(vec[i], 1'b1);
         n_checks++;
         if ({bus.out, bus.valid} !== {idx[i], 1'b1})
            $display("FAIL multi_hot[%h]: out=%0d valid=%b, want out=%0d valid=1",
                     vec[i], bus.out, bus.valid, idx[i]);
         else n_passed++;
      end
   endtask

   task automatic test_zero();
      capture(8'h00, 1'b1);
      n_checks++;
      if ({bus.out, bus.valid} !== {3'd0, 1'b0})
         $display("FAIL zero_input: out=%0d valid=%b, want out=0 valid=0",
                  bus.out, bus.valid);
      else n_passed++;
      capture(8'h01, 1'b1);
      n_checks++;
      if ({bus.out, bus.valid} !== {3'd0, 1'b1})
         $display("FAIL bit0_input: out=%0d valid=%b, want out=0 valid=1",
                  bus.out, bus.valid);
      else n_passed++;
   endtask

   task automatic test_enable_hold();
      capture(8'h40, 1'b1);
      n_checks++;
      if ({bus.out, bus.valid} !== {3'd6, 1'b1})
         $display("FAIL hold_capture: out=%0d valid=%b, want out=6 valid=1",
                  bus.out, bus.valid);
      else n_passed++;
      for (int k = 0; k < 3; k++) begin
         capture(8'h01, 1'b0);
         n_checks++;
         if ({bus.out, bus.valid} !== {3'd6, 1'b1})
            $display("FAIL hold_en0[%0d]: out=%0d valid=%b, want out=6 valid=1",
                     k, bus.out, bus.valid);
         else n_passed++;
      end
   endtask

   task automatic test_async_reset();
      capture(8'h80, 1'b1);
      n_checks++;
      if ({bus.out, bus.valid} !== {3'd7, 1'b1})
         $display("FAIL async_pre: out=%0d valid=%b, want out=7 valid=1",
                  bus.out, bus.valid);
      else n_passed++;
      // Mid-cycle: rising edge was 1 unit ago, falling edge is 4 units away.
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.out, bus.valid} !== {3'd0, 1'b0})
         $display("FAIL async_drop: out=%0d valid=%b, want out=0 valid=0",
                  bus.out, bus.valid);
      else n_passed++;
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.out, bus.valid} !== {3'd0, 1'b0})
         $display("FAIL async_held: out=%0d valid=%b, want out=0 valid=0",
                  bus.out, bus.valid);
      else n_passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [N-1:0] v;
      logic         e;
      logic [2:0]   exp_out;
      logic         exp_valid;
      // Establish a known held value before enable is randomised.
      capture(8'h00, 1'b1);
      exp_out   = 3'd0;
      exp_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         v = N'($urandom);
         // Thin out high bits sometimes so low indices also show up.
         if ($urandom_range(0, 2) == 0) v = v >> $urandom_range(1, 7);
         e = ($urandom_range(0, 3) != 0);
         capture(v, e);
         if (e) begin
            exp_out   = ref_idx(v);
            exp_valid = ref_valid(v);
         end
         n_checks++;
         if ({bus.out, bus.valid} !== {exp_out, exp_valid})
            $display("FAIL random[%0d] in=%h en=%b: out=%0d valid=%b, want out=%0d valid=%b",
                     k, v, e, bus.out, bus.valid, exp_out, exp_valid);
         else n_passed++;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      bus.in = '0;
      bus.en = 1'b0;
      test_reset();
      test_one_hot();
      test_multi_hot();
      test_zero();
      test_enable_hold();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule : tb_encoder_8to3

// File: doc/encoder_8to3.md
Name: encoder_8to3

Overview:
- Registered 8-to-3 priority encoder.
- Samples an 8-bit request vector each clock and outputs the index of the highest-numbered asserted bit, plus a valid flag that is high when any bit is set.
- Used as a small arbitration/index front end wherever a one-hot or multi-hot request vector must be reduced to a binary index.
- Outputs are registered: one-cycle latency, clean timing to downstream logic.

Parameters:
- N, 8, width of the input request vector. Must be a power of two, 2 to 64.
- OUT_W, $clog2(N), width of the encoded index; derived, not overridden.
- REG_OUT, 1: 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational from `in` (clk/rst_n unused).

Ports:
- clk    input   1      single clock, rising-edge active.
- rst_n  input   1      asynchronous, active-low reset.
- en     input   1      capture enable; when 0 the output registers hold.
- in     input   N      request vector; bit i = request i.
- out    output  OUT_W  index of highest-priority asserted bit.
- valid  output  1      1 when any bit of the sampled `in` was 1.

Behaviour:
- Interface fixed: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- Reset: `rst_n` = 0 forces out = 0 and valid = 0 immediately, independent of `clk`, including mid-operation. Outputs stay 0 while `rst_n` is low.
- First capture happens on the first rising `clk` with `rst_n` = 1 and `en` = 1.
- Priority: bit N-1 highest, bit 0 lowest. `out` = largest i with in[i] = 1.
  - Examples for N = 8: 1xxxxxxx -> 7, 01xxxxxx -> 6, ..., 00000001 -> 0.
- Lower-priority bits are ignored entirely; any multi-hot vector is legal and encodes to its MSB index.
- All-zero input: out = 0, valid = 0. `out` = 0 with valid = 0 is the only indication of "no request"; consumers must qualify `out` with `valid`.
- valid = OR-reduction of `in`.
- Latency (REG_OUT = 1): `in` sampled at rising edge k with en = 1 appears on out/valid after edge k and holds until the next enabled edge.
- Enable: en = 0 at a rising edge leaves out/valid unchanged. en has no effect during reset.
- REG_OUT = 0: out/valid follow `in` combinationally with no clock dependency; reset and en are ignored.
- X handling: no X on outputs after reset when `in` is fully driven. Outputs never depend on uninitialised state.
- Purely combinational priority logic feeds the registers. No internal state other than the output registers.

Test Plan:
- Reset: hold rst_n = 0 with in = 8'hFF, en = 1 and clocks running -> out = 0, valid = 0 throughout. Deassert rst_n -> after the next edge, out = 7, valid = 1.
- One-hot sweep: apply in = 1<<i for i = 0..7, one per enabled clock -> each cycle after capture, out = i and valid = 1.
- Multi-hot priority:
  - in = 8'b00000011 -> out = 1, valid = 1.
  - 8'b10101010 -> out = 7, valid = 1.
  - 8'b11111111 -> out = 7, valid = 1.
  - 8'b00010110 -> out = 4, valid = 1.
- Zero input: in = 8'h00 -> out = 0, valid = 0. Then in = 8'h01 -> out = 0, valid = 1; valid alone distinguishes the two cases.
- Enable hold and async reset:
  - Capture in = 8'h40 (out = 6), then set en = 0 and in = 8'h01 for 3 clocks -> out stays 6, valid stays 1.
  - Pulse rst_n low between clock edges -> out/valid drop to 0 immediately, without waiting for `clk`.
- Random: at least 10 random in values with en = 1, each checked against a reference model (MSB index, OR-reduction) one cycle after capture -> zero mismatches.
